rf_write_arbiter: RTL and testbench



---
 rtl/rf_write_arbiter_pkg.sv | 15 +
 rtl/rf_write_arbiter_decoder_5x32.sv | 17 +
 rtl/rf_write_arbiter.sv | 115 +++++++++++
 tb/tb_rf_write_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// Register-file write arbiter: shared constants and requester IDs.
// Imported by the arbiter top and its address decoder.
package rf_write_arbiter_pkg;

  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int RF_DEPTH    = 32;
  localparam int RF_ZERO_REG = 0;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

endpackage

// File: rtl/rf_write_arbiter_decoder_5x32.sv
// Binary-to-one-hot register select decoder (5x32 by default).
// Ports: addr (binary index) -> onehot (exactly one bit set).
module rf_write_arbiter_decoder_5x32
  import rf_write_arbiter_pkg::*;
#(
  parameter int AW = RF_ADDR_W
) (
  input  logic [AW-1:0]      addr,
  output logic [2**AW-1:0]   onehot
);

  always_comb begin
    onehot       = '0;
    onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the RF write port between ALU (0) and
// load return (1). Ports: CLK/RESET/HOLD, REQn_* handshakes, WLOAD/
// WDATA/WADDR/WVALID/GNT_ID output stage, DROPS saturating R0 count.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DROP_W = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 HOLD,
  input  logic                 REQ0_VALID,
  input  logic [ADDR_W-1:0]    REQ0_ADDR,
  input  logic [DATA_W-1:0]    REQ0_DATA,
  output logic                 REQ0_READY,
  input  logic                 REQ1_VALID,
  input  logic [ADDR_W-1:0]    REQ1_ADDR,
  input  logic [DATA_W-1:0]    REQ1_DATA,
  output logic                 REQ1_READY,
  output logic [2**ADDR_W-1:0] WLOAD,
  output logic [DATA_W-1:0]    WDATA,
  output logic [ADDR_W-1:0]    WADDR,
  output logic                 WVALID,
  output logic                 GNT_ID,
  output logic [DROP_W-1:0]    DROPS
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_REG);

  req_id_e             rr;
  req_id_e             gnt_id_q;
  logic                gnt0;
  logic                gnt1;
  logic                acc0;
  logic                acc1;
  logic                acc;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                wvalid_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DROP_W-1:0]   drops_q;
  logic [DEPTH-1:0]    dec_onehot;

  always_comb begin
    gnt0 = REQ0_VALID & (~REQ1_VALID | (rr == REQ_ALU));
    gnt1 = REQ1_VALID & (~REQ0_VALID | (rr == REQ_MEM));
  end

  // READY is also forced low while reset is held.
  assign acc0 = gnt0 & ~HOLD & RESET;
  assign acc1 = gnt1 & ~HOLD & RESET;
  assign acc  = acc0 | acc1;

  assign REQ0_READY = acc0;
  assign REQ1_READY = acc1;

  assign sel_addr = acc1 ? REQ1_ADDR : REQ0_ADDR;
  assign sel_data = acc1 ? REQ1_DATA : REQ0_DATA;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rr <= REQ_ALU;
    end else if (acc0) begin
      rr <= REQ_MEM;
    end else if (acc1) begin
      rr <= REQ_ALU;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wvalid_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      gnt_id_q <= REQ_ALU;
    end else begin
      wvalid_q <= acc;
      if (acc) begin
        waddr_q  <= sel_addr;
        wdata_q  <= sel_data;
        gnt_id_q <= acc1 ? REQ_MEM : REQ_ALU;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      drops_q <= '0;
    end else if (acc && (sel_addr == ZERO_ADDR)
                 && (drops_q != '1)) begin
      drops_q <= drops_q + DROP_W'(1);
    end
  end

  rf_write_arbiter_decoder_5x32 #(
    .AW(ADDR_W)
  ) u_dec (
    .addr   (waddr_q),
    .onehot (dec_onehot)
  );

  // R0 is hardwired zero: its write is acknowledged but never loaded.
  assign WLOAD  = dec_onehot
                & {DEPTH{wvalid_q & (waddr_q != ZERO_ADDR)}};
  assign WDATA  = wdata_q;
  assign WADDR  = waddr_q;
  assign WVALID = wvalid_q;
  assign GNT_ID = gnt_id_q;
  assign DROPS  = drops_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a register-bank model.
// Expected values are hand-computed per scenario.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold;
  logic        v0, v1;
  logic [4:0]  a0, a1;
  logic [31:0] d0, d1;
  logic        r0, r1;
  logic [31:0] wload;
  logic [31:0] wdata;
  logic [4:0]  waddr;
  logic        wvalid;
  logic        gnt_id;
  logic [7:0]  drops;

  int checks = 0;
  int errors = 0;

  logic [31:0] bank [32];

  rf_write_arbiter dut (
    .CLK        (clk),
    .RESET      (rst_n),
    .HOLD       (hold),
    .REQ0_VALID (v0),
    .REQ0_ADDR  (a0),
    .REQ0_DATA  (d0),
    .REQ0_READY (r0),
    .REQ1_VALID (v1),
    .REQ1_ADDR  (a1),
    .REQ1_DATA  (d1),
    .REQ1_READY (r1),
    .WLOAD      (wload),
    .WDATA      (wdata),
    .WADDR      (waddr),
    .WVALID     (wvalid),
    .GNT_ID     (gnt_id),
    .DROPS      (drops)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 32; i++)
      if (wload[i]) bank[i] <= wdata;
  end

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n)
      check("wload_onehot",
            {63'd0, ($countones(wload) <= 1)}, 64'd1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    hold  = 1'b0;
    v0 = 1'b1; a0 = 5'd5; d0 = 32'hDEADBEEF;
    v1 = 1'b0; a1 = 5'd0; d1 = 32'h0;
    #2;
    check("rst_ready0", r0, 0);
    check("rst_wload", wload, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_wdata", wdata, 0);
    check("rst_waddr", waddr, 0);
    check("rst_gnt", gnt_id, 0);
    check("rst_drops", drops, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;

    // single ALU write to r5
    check("t1_ready0", r0, 1);
    check("t1_ready1", r1, 0);
    step();
    v0 = 1'b0;
    check("t1_wvalid", wvalid, 1);
    check("t1_wload", wload, 32'h20);
    check("t1_wdata", wdata, 32'hDEADBEEF);
    check("t1_waddr", waddr, 5);
    check("t1_gnt", gnt_id, 0);
    step();
    check("t1_idle_wvalid", wvalid, 0);
    check("t1_idle_wload", wload, 0);
    check("t1_idle_wdata", wdata, 32'hDEADBEEF);

    // req1-only write returns RR to 0
    v1 = 1'b1; a1 = 5'd2; d1 = 32'h2222;
    #1 check("t1b_ready1", r1, 1);
    step();
    v1 = 1'b0;
    check("t1b_wload", wload, 32'h4);
    check("t1b_gnt", gnt_id, 1);

    // both valid, RR=0: 0 then 1
    v0 = 1'b1; a0 = 5'd3; d0 = 32'h33;
    v1 = 1'b1; a1 = 5'd7; d1 = 32'h77;
    #1;
    check("t2_ready0", r0, 1);
    check("t2_ready1", r1, 0);
    step();
    v0 = 1'b0;
    check("t2_wload_a", wload, 32'h8);
    check("t2_gnt_a", gnt_id, 0);
    #1 check("t2_ready1_b", r1, 1);
    step();
    v1 = 1'b0;
    check("t2_wload_b", wload, 32'h80);
    check("t2_gnt_b", gnt_id, 1);
    check("t2_wvalid_b", wvalid, 1);

    // req0-only to set RR=1
    v0 = 1'b1; a0 = 5'd10; d0 = 32'hAAAA;
    #1 check("t3a_ready0", r0, 1);
    step();
    v0 = 1'b0;
    check("t3a_wload", wload, 32'h400);

    // same address 9, RR=1: req1 first, req0 last
    v0 = 1'b1; a0 = 5'd9; d0 = 32'h11;
    v1 = 1'b1; a1 = 5'd9; d1 = 32'h22;
    #1;
    check("t3_ready1", r1, 1);
    check("t3_ready0", r0, 0);
    step();
    v1 = 1'b0;
    check("t3_gnt_a", gnt_id, 1);
    check("t3_wdata_a", wdata, 32'h22);
    #1 check("t3_ready0_b", r0, 1);
    step();
    v0 = 1'b0;
    check("t3_gnt_b", gnt_id, 0);
    check("t3_wdata_b", wdata, 32'h11);
    check("t3_wload_b", wload, 32'h200);
    step();
    check("t3_bank9", bank[9], 32'h11);
    check("t3_bank5", bank[5], 32'hDEADBEEF);
    check("t3_bank3", bank[3], 32'h33);
    check("t3_bank7", bank[7], 32'h77);

    // R0 writes from req1
    v1 = 1'b1; a1 = 5'd0; d1 = 32'h5A5A;
    for (int i = 0; i < 3; i++) begin
      #1 check("t4_ready1", r1, 1);
      step();
      check("t4_wvalid", wvalid, 1);
      check("t4_wload", wload, 0);
      check("t4_waddr", waddr, 0);
    end
    check("t4_drops3", drops, 3);
    for (int i = 0; i < 251; i++) step();
    check("t4_drops254", drops, 254);
    step();
    check("t4_drops255", drops, 255);
    for (int i = 0; i < 46; i++) step();
    check("t4_drops_sat", drops, 255);
    v1 = 1'b0;
    step();
    check("t4_idle_wvalid", wvalid, 0);

    // HOLD blocks grants
    v0 = 1'b1; a0 = 5'd12; d0 = 32'hC0C0C0C0;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("t5_ready0_hold", r0, 0);
      step();
      check("t5_wvalid_hold", wvalid, 0);
      check("t5_wload_hold", wload, 0);
    end
    hold = 1'b0;
    #1 check("t5_ready0_rel", r0, 1);
    step();
    v0 = 1'b0;
    check("t5_wload_rel", wload, 32'h1000);
    check("t5_wdata_rel", wdata, 32'hC0C0C0C0);

    // HOLD does not cancel a registered stage
    v1 = 1'b1; a1 = 5'd13; d1 = 32'h1313;
    #1 check("t5b_ready1", r1, 1);
    step();
    hold = 1'b1;
    v1 = 1'b0;
    check("t5b_wvalid", wvalid, 1);
    check("t5b_wload", wload, 32'h2000);
    step();
    check("t5b_wvalid_next", wvalid, 0);
    hold = 1'b0;

    // async reset mid-cycle
    v0 = 1'b1; a0 = 5'd4; d0 = 32'h44;
    #1 check("t6_ready0", r0, 1);
    step();
    v0 = 1'b0;
    v1 = 1'b1; a1 = 5'd20; d1 = 32'h2020;
    check("t6_wvalid_pre", wvalid, 1);
    check("t6_wload_pre", wload, 32'h10);
    check("t6_drops_pre", drops, 255);
    #2 rst_n = 1'b0;
    #1;
    check("t6_wload_rst", wload, 0);
    check("t6_wvalid_rst", wvalid, 0);
    check("t6_drops_rst", drops, 0);
    check("t6_waddr_rst", waddr, 0);
    check("t6_ready1_rst", r1, 0);
    #2 rst_n = 1'b1;
    v0 = 1'b1; a0 = 5'd6; d0 = 32'h66;
    v1 = 1'b1; a1 = 5'd8; d1 = 32'h88;
    #1;
    check("t6_ready0_post", r0, 1);
    check("t6_ready1_post", r1, 0);
    step();
    v0 = 1'b0;
    check("t6_gnt_a", gnt_id, 0);
    check("t6_wload_a", wload, 32'h40);
    #1 check("t6_ready1_b", r1, 1);
    step();
    v1 = 1'b0;
    check("t6_gnt_b", gnt_id, 1);
    check("t6_wload_b", wload, 32'h100);
    step();
    check("t6_bank6", bank[6], 32'h66);
    check("t6_bank8", bank[8], 32'h88);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
